// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared definitions for the ID/EX control stage: FSM encoding, drain timer width
// and the layout of the opaque decoded control bundle.
package id_ex_ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_t;

    localparam int DRAIN_CNT_W = 4;

    // Field offsets inside the 24-bit control bundle, shared by decode and EX
    localparam int CTRL_ALU_OP_LSB    = 0;
    localparam int CTRL_ALU_OP_W      = 5;
    localparam int CTRL_ALU_SRC_BIT   = 5;
    localparam int CTRL_MEM_WRITE_BIT = 6;
    localparam int CTRL_BRANCH_BIT    = 7;
    localparam int CTRL_JUMP_BIT      = 8;
    localparam int CTRL_IMM_LSB       = 9;
    localparam int CTRL_IMM_W         = 15;

endpackage

// File: rtl/id_ex_ctrl_pipe_load_use_detect.sv
// Load-use hazard compare between the instruction in ID and a load sitting in EX.
// Purely combinational so forwarding logic can reuse the same specifier match.
module load_use_detect #(
    parameter int REG_AW = 3
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dst,
    output logic              hz
);

    logic rs_match;
    logic rt_match;

    // No register is exempt: r0 is treated like any other destination
    assign rs_match = id_uses_rs & (id_rs == ex_dst);
    assign rt_match = id_uses_rt & (id_rt == ex_dst);

    assign hz = id_valid & ex_valid & ex_mem_read & ex_reg_write & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// Registered decode-to-execute control stage with load-use bubbles, flush squash
// and a timed halt drain before reporting the processor as halted.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_RUN    | normal issue; accepts instructions from ID
//   ST_DRAIN  | halt is in EX; only bubbles issue while older instrs retire
//   ST_HALTED | pipeline empty, halted=1; left only through reset
module id_ex_ctrl_pipe
    import id_ex_ctrl_pipe_pkg::*;
#(
    parameter int CTRL_W       = 24,
    parameter int REG_AW       = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_halt,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_halt,
    output logic              halted
);

    pipe_state_t            state;
    pipe_state_t            state_nxt;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [DRAIN_CNT_W-1:0] drain_cnt_nxt;
    logic                   hz;
    logic                   accept;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .hz           (hz)
    );

    assign accept   = id_valid & ~hz & ~flush & (state == ST_RUN);
    // A flushed instruction is dropped, so it must not also hold the front end
    assign id_stall = (hz & ~flush) | (state != ST_RUN);
    assign halted   = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_RUN: begin
                if (accept && id_halt) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !accept) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_dst       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_halt      <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_ctrl      <= id_ctrl;
            ex_dst       <= id_dst;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_halt      <= id_halt;
        end
    end

endmodule
